// File: rtl/noc_rr_switch_alloc.sv
// Switch allocator: one round-robin arbiter per output, with packet locking and registered grants.
// Optional lock-stall timeout is enabled by defining SA_LOCK_TIMEOUT_EN.
//
// state     | meaning
// ST_IDLE   | output free; arbitrate among requesters starting after ptr
// ST_LOCKED | output held by owner until its tail flit is granted
module noc_rr_switch_alloc #(
  parameter int NUM_PORTS    = 5,
  parameter int PORT_W       = 3,
  parameter int LOCK_TIMEOUT = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_PORTS*NUM_PORTS-1:0] req_i,
  input  logic [NUM_PORTS-1:0]          tail_i,
  input  logic [NUM_PORTS-1:0]          en_i,
  output logic [NUM_PORTS-1:0]          gnt_valid_o,
  output logic [NUM_PORTS*PORT_W-1:0]   gnt_port_o,
  output logic [NUM_PORTS-1:0]          lock_o,
  output logic [NUM_PORTS-1:0]          lock_err_o
);

  localparam logic [0:0] ST_IDLE   = 1'b0;
  localparam logic [0:0] ST_LOCKED = 1'b1;

  logic [NUM_PORTS-1:0][NUM_PORTS-1:0] req_s;
  logic [NUM_PORTS-1:0]                gnt_out;
  logic [PORT_W-1:0]                   gnt_in [NUM_PORTS];
  logic [NUM_PORTS-1:0]                nxt_valid;
  logic [PORT_W-1:0]                   nxt_port [NUM_PORTS];

  // Keep only the lowest requested output per input (x & -x isolates the lowest set bit).
  for (genvar i = 0; i < NUM_PORTS; i++) begin : g_in
    logic [NUM_PORTS-1:0] row;
    assign row      = req_i[i*NUM_PORTS +: NUM_PORTS];
    assign req_s[i] = row & (~row + 1'b1);
  end

  for (genvar j = 0; j < NUM_PORTS; j++) begin : g_out
    logic [NUM_PORTS-1:0] col;
    logic [0:0]           state;
    logic [PORT_W-1:0]    ptr;
    logic [PORT_W-1:0]    owner;
    logic                 win_found;
    logic [PORT_W-1:0]    win_idx;
    logic                 gnt;
    logic [PORT_W-1:0]    gnt_idx;
    logic                 err;

    for (genvar i = 0; i < NUM_PORTS; i++) begin : g_col
      assign col[i] = req_s[i][j];
    end

    // Two descending passes: the last hit wins, so candidates above ptr beat those at or below it.
    always_comb begin
      win_found = 1'b0;
      win_idx   = '0;
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
        if (col[i] && (PORT_W'(i) <= ptr)) begin
          win_found = 1'b1;
          win_idx   = PORT_W'(i);
        end
      end
      for (int i = NUM_PORTS - 1; i >= 0; i--) begin
        if (col[i] && (PORT_W'(i) > ptr)) begin
          win_found = 1'b1;
          win_idx   = PORT_W'(i);
        end
      end
    end

    always_comb begin
      gnt     = 1'b0;
      gnt_idx = '0;
      if (state == ST_IDLE) begin
        if (en_i[j] && win_found) begin
          gnt     = 1'b1;
          gnt_idx = win_idx;
        end
      end else if (en_i[j] && col[owner]) begin
        gnt     = 1'b1;
        gnt_idx = owner;
      end
    end

`ifdef SA_LOCK_TIMEOUT_EN
    logic [7:0] stall_cnt;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state     <= ST_IDLE;
        ptr       <= PORT_W'(NUM_PORTS - 1);
        owner     <= '0;
        stall_cnt <= '0;
        err       <= 1'b0;
      end else begin
        err <= 1'b0;
        if (gnt) begin
          stall_cnt <= '0;
          if (state == ST_IDLE) begin
            ptr <= win_idx;
            if (!tail_i[win_idx]) begin
              state <= ST_LOCKED;
              owner <= win_idx;
            end
          end else if (tail_i[owner]) begin
            state <= ST_IDLE;
          end
        end else if (state == ST_IDLE) begin
          stall_cnt <= '0;
        end else if (en_i[j]) begin
          if (stall_cnt == 8'(LOCK_TIMEOUT - 1)) begin
            state     <= ST_IDLE;
            stall_cnt <= '0;
            err       <= 1'b1;
          end else begin
            stall_cnt <= stall_cnt + 8'd1;
          end
        end
      end
    end
`else
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        state <= ST_IDLE;
        ptr   <= PORT_W'(NUM_PORTS - 1);
        owner <= '0;
      end else if (gnt) begin
        if (state == ST_IDLE) begin
          ptr <= win_idx;
          if (!tail_i[win_idx]) begin
            state <= ST_LOCKED;
            owner <= win_idx;
          end
        end else if (tail_i[owner]) begin
          state <= ST_IDLE;
        end
      end
    end

    assign err = 1'b0;
`endif

    assign gnt_out[j]    = gnt;
    assign gnt_in[j]     = gnt_idx;
    assign lock_o[j]     = (state == ST_LOCKED);
    assign lock_err_o[j] = err;
  end

  // Each input asks for at most one output, so at most one output can name it.
  always_comb begin
    for (int i = 0; i < NUM_PORTS; i++) begin
      nxt_valid[i] = 1'b0;
      nxt_port[i]  = '0;
      for (int j = 0; j < NUM_PORTS; j++) begin
        if (gnt_out[j] && (gnt_in[j] == PORT_W'(i))) begin
          nxt_valid[i] = 1'b1;
          nxt_port[i]  = PORT_W'(j);
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      gnt_valid_o <= '0;
      gnt_port_o  <= '0;
    end else begin
      gnt_valid_o <= nxt_valid;
      for (int i = 0; i < NUM_PORTS; i++) begin
        if (nxt_valid[i]) gnt_port_o[i*PORT_W +: PORT_W] <= nxt_port[i];
      end
    end
  end

endmodule

// File: tb/tb_noc_rr_switch_alloc.sv
// Directed bench for noc_rr_switch_alloc: reset, round-robin, locking, backpressure, parallel grants.
module tb_noc_rr_switch_alloc;

  localparam int N = 5;
  localparam int W = 3;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N*N-1:0] req;
  logic [N-1:0]   tail;
  logic [N-1:0]   en;
  logic [N-1:0]   gnt_valid;
  logic [N*W-1:0] gnt_port;
  logic [N-1:0]   lock;
  logic [N-1:0]   lock_err;

  int n_pass  = 0;
  int n_total = 0;

  noc_rr_switch_alloc #(.NUM_PORTS(N), .PORT_W(W), .LOCK_TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .req_i(req), .tail_i(tail), .en_i(en),
    .gnt_valid_o(gnt_valid), .gnt_port_o(gnt_port), .lock_o(lock), .lock_err_o(lock_err)
  );

  always #5 clk = ~clk;

  function automatic logic [W-1:0] port_of(input int i);
    return gnt_port[i*W +: W];
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst  = 1'b1;
    req  = '0;
    tail = '1;
    en   = '1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    n_total++;
    if (gnt_valid !== 5'b0 || gnt_port !== '0 || lock !== 5'b0 || lock_err !== 5'b0) begin
      $display("FAIL reset_state: valid=%b port=%h lock=%b err=%b, need all 0", gnt_valid, gnt_port, lock, lock_err);
    end else n_pass++;
    req = '0; req[4*N+2] = 1'b1; tail[4] = 1'b0;
    cyc();
    n_total++;
    if (gnt_valid !== 5'b10000 || lock !== 5'b00100) begin
      $display("FAIL reset_prelock: valid=%b lock=%b, need 10000/00100", gnt_valid, lock);
    end else n_pass++;
    #2 rst = 1'b1;
    #1;
    n_total++;
    if (gnt_valid !== 5'b0 || gnt_port !== '0 || lock !== 5'b0 || lock_err !== 5'b0) begin
      $display("FAIL reset_async: valid=%b port=%h lock=%b err=%b, need all 0", gnt_valid, gnt_port, lock, lock_err);
    end else n_pass++;
    #3 rst = 1'b0;
    req = '0; req[0*N+2] = 1'b1; req[3*N+2] = 1'b1; tail = '1;
    cyc();
    n_total++;
    if (gnt_valid !== 5'b00001 || port_of(0) !== 3'd2) begin
      $display("FAIL reset_first_prio: valid=%b port0=%0d, need 00001/2", gnt_valid, port_of(0));
    end else n_pass++;
    cyc();
    n_total++;
    if (gnt_valid !== 5'b01000 || port_of(3) !== 3'd2) begin
      $display("FAIL reset_second: valid=%b port3=%0d, need 01000/2", gnt_valid, port_of(3));
    end else n_pass++;
  endtask

  task automatic test_rr_fairness();
    int exp_seq [6] = '{0, 2, 4, 0, 2, 4};
    do_reset();
    req = '0; req[0*N+1] = 1'b1; req[2*N+1] = 1'b1; req[4*N+1] = 1'b1;
    for (int c = 0; c < 6; c++) begin
      cyc();
      n_total++;
      if (gnt_valid !== (5'b1 << exp_seq[c]) || port_of(exp_seq[c]) !== 3'd1) begin
        $display("FAIL rr_cycle%0d: valid=%b port=%0d, need input %0d port 1", c, gnt_valid, port_of(exp_seq[c]), exp_seq[c]);
      end else n_pass++;
    end
    req = '0;
  endtask

  task automatic test_lock();
    int lock_cycles = 0;
    do_reset();
    req = '0; req[3*N+0] = 1'b1; tail[3] = 1'b0;
    for (int f = 0; f < 4; f++) begin
      if (f == 1) begin
        req[1*N+0] = 1'b1;
        tail[1]    = 1'b1;
      end
      tail[3] = (f == 3);
      cyc();
      if (lock[0]) lock_cycles++;
      n_total++;
      if (gnt_valid !== 5'b01000 || port_of(3) !== 3'd0) begin
        $display("FAIL lock_flit%0d: valid=%b port3=%0d, need 01000/0", f, gnt_valid, port_of(3));
      end else n_pass++;
    end
    n_total++;
    if (lock_cycles !== 3) begin
      $display("FAIL lock_cycles: got %0d, need 3", lock_cycles);
    end else n_pass++;
    req[3*N+0] = 1'b0;
    cyc();
    n_total++;
    if (gnt_valid !== 5'b00010 || port_of(1) !== 3'd0 || lock[0] !== 1'b0) begin
      $display("FAIL lock_next: valid=%b port1=%0d lock0=%b, need 00010/0/0", gnt_valid, port_of(1), lock[0]);
    end else n_pass++;
    req = '0;
  endtask

  task automatic test_backpressure();
    do_reset();
    req = '0; req[4*N+2] = 1'b1; tail[4] = 1'b0;
    cyc();
    n_total++;
    if (gnt_valid !== 5'b10000 || lock[2] !== 1'b1) begin
      $display("FAIL bp_head: valid=%b lock2=%b, need 10000/1", gnt_valid, lock[2]);
    end else n_pass++;
    en[2] = 1'b0;
    for (int c = 0; c < 5; c++) begin
      cyc();
      n_total++;
      if (gnt_valid !== 5'b0 || lock[2] !== 1'b1 || port_of(4) !== 3'd2) begin
        $display("FAIL bp_stall%0d: valid=%b lock2=%b port4=%0d, need 0/1/2", c, gnt_valid, lock[2], port_of(4));
      end else n_pass++;
    end
    en = '1; tail[4] = 1'b1;
    cyc();
    n_total++;
    if (gnt_valid !== 5'b10000 || port_of(4) !== 3'd2 || lock[2] !== 1'b0) begin
      $display("FAIL bp_resume: valid=%b port4=%0d lock2=%b, need 10000/2/0", gnt_valid, port_of(4), lock[2]);
    end else n_pass++;
    req = '0;
    en  = 5'b11110;
    req[1*N+0] = 1'b1;
    cyc();
    n_total++;
    if (gnt_valid !== 5'b0) begin
      $display("FAIL bp_idle_disabled: valid=%b, need 00000", gnt_valid);
    end else n_pass++;
    en = '1; req = '0;
  endtask

  task automatic test_parallel();
    do_reset();
    req = '0;
    for (int i = 0; i < N; i++) req[i*N + (N-1-i)] = 1'b1;
    cyc();
    n_total++;
    if (gnt_valid !== 5'b11111 || gnt_port !== {3'd0, 3'd1, 3'd2, 3'd3, 3'd4}) begin
      $display("FAIL parallel: valid=%b port=%h, need 11111/%h", gnt_valid, gnt_port, {3'd0, 3'd1, 3'd2, 3'd3, 3'd4});
    end else n_pass++;
    req = '0;
    req[2*N+1] = 1'b1; req[2*N+3] = 1'b1; req[0*N+3] = 1'b1;
    cyc();
    n_total++;
    if (gnt_valid !== 5'b00101 || port_of(2) !== 3'd1 || port_of(0) !== 3'd3) begin
      $display("FAIL sanitise: valid=%b port2=%0d port0=%0d, need 00101/1/3", gnt_valid, port_of(2), port_of(0));
    end else n_pass++;
    req = '0;
    cyc();
    n_total++;
    if (gnt_valid !== 5'b0 || port_of(2) !== 3'd1 || lock_err !== 5'b0) begin
      $display("FAIL port_hold: valid=%b port2=%0d err=%b, need 0/1/0", gnt_valid, port_of(2), lock_err);
    end else n_pass++;
  endtask

`ifdef SA_LOCK_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    req = '0; req[0*N+0] = 1'b1; tail[0] = 1'b0;
    cyc();
    req = '0;
    for (int s = 1; s <= 15; s++) begin
      cyc();
      n_total++;
      if (lock_err[0] !== 1'b0 || lock[0] !== 1'b1) begin
        $display("FAIL timeout_stall%0d: err0=%b lock0=%b, need 0/1", s, lock_err[0], lock[0]);
      end else n_pass++;
    end
    req[2*N+0] = 1'b1; tail[2] = 1'b1;
    cyc();
    n_total++;
    if (lock_err !== 5'b00001 || lock[0] !== 1'b0 || gnt_valid !== 5'b0) begin
      $display("FAIL timeout_fire: err=%b lock0=%b valid=%b, need 00001/0/0", lock_err, lock[0], gnt_valid);
    end else n_pass++;
    cyc();
    n_total++;
    if (lock_err !== 5'b0 || gnt_valid !== 5'b00100 || port_of(2) !== 3'd0) begin
      $display("FAIL timeout_rearb: err=%b valid=%b port2=%0d, need 0/00100/0", lock_err, gnt_valid, port_of(2));
    end else n_pass++;
    req = '0;
  endtask
`endif

  initial begin
    req  = '0;
    tail = '1;
    en   = '1;
    test_reset();
    test_rr_fairness();
    test_lock();
    test_backpressure();
    test_parallel();
`ifdef SA_LOCK_TIMEOUT_EN
    test_timeout();
`endif
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
